alu_seq_core: RTL
=================

Name: alu_seq_core

Overview:
- Parametrised successor to the 8-bit one-hot-select ALU top.
- Registered operand pair with persist/load/reset input select, explicit start strobe, and a 4-state controller exported as curr_state/next_state.
- Adds a registered result, flags, valid/busy handshake, a multi-cycle shift-add multiplier returning the full 2*WIDTH product, and an illegal-op error flag.
- Sits between operand sources and the result bus; it is the DUT of the next-generation bench.

Parameters:
- WIDTH, 8, operand/result width; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- on  in  1  enable; 0 forces OFF
- in_sel  in  3  one-hot operand select: [2]=persist, [1]=load, [0]=reset
- num1  in  WIDTH  operand A source
- num2  in  WIDTH  operand B source
- out_sel  in  7  one-hot op: [6]ADD [5]SUB [4]MUL [3]AND [2]OR [1]XOR [0]NOT(A)
- start  in  1  execute request, sampled only in READY
- out  out  WIDTH  result (low half for MUL)
- out_hi  out  WIDTH  MUL high half, else 0
- carry  out  1  ADD carry-out / SUB borrow
- ovf  out  1  signed overflow for ADD/SUB; out_hi!=0 for MUL
- zero  out  1  full result == 0
- err  out  1  illegal out_sel on last op
- valid  out  1  result valid, one-cycle pulse
- busy  out  1  high while in BUSY
- curr_state  out  2  registered state
- next_state  out  2  combinational next state

Behaviour:
- Reset (rst=0, async): state=OFF; A, B, out, out_hi, all flags, valid, busy = 0.
- States: OFF=00, READY=01, BUSY=10, DONE=11.
  - OFF -> READY when on=1.
  - READY -> BUSY on start with out_sel=MUL.
  - READY -> DONE on start with any other out_sel, legal or not.
  - BUSY -> DONE after exactly WIDTH cycles in BUSY.
  - DONE -> READY unconditionally; start in DONE is ignored.
  - on=0 in any state -> OFF next edge. An in-flight MUL is aborted; no valid is produced.
- Operand registers:
  - Priority reset > load > persist. 000 = persist. Multi-hot resolved by that priority.
  - Updated only in OFF/READY/DONE; frozen in BUSY, where in_sel is ignored.
- Start uses A/B as held before the start edge. A load on the same edge affects only the next op. MUL snapshots A/B into its working registers at start.
- Latency (start edge = T):
  - Non-MUL: out/flags registered at T and valid in the DONE cycle, i.e. valid high at T+1.
  - MUL: valid high at T+WIDTH+1.
  - valid is high exactly while state=DONE.
- Outputs out, out_hi and flags hold their last value until the next completed op. OFF does not clear them; only reset does.
- Arithmetic, unsigned modulo 2^WIDTH:
  - ADD: carry = bit WIDTH of A+B.
  - SUB: carry = (A<B); ovf = signed overflow.
  - MUL: {out_hi,out} = A*B; carry = 0.
  - Logic ops and NOT: carry = ovf = 0; out_hi = 0.
- Illegal out_sel (zero or multi-hot): out=0, out_hi=0, err=1, other flags 0. Still goes through DONE with valid=1.
- err is cleared by the next legal op.
- busy = (state==BUSY).

Decomposition:
- alu_pkg holds:
  - state encodings ST_OFF/ST_READY/ST_BUSY/ST_DONE
  - out_sel bit indices OP_ADD..OP_NOT
  - in_sel bit indices SEL_PERSIST/SEL_LOAD/SEL_RESET
- Sub-module alu_seq_mul, parametrised by WIDTH:
  - shift-add, one multiplier bit per cycle
  - ports: clk, rst, go, abort, a, b, done, product[2*WIDTH-1:0]

Test Plan:
- Reset, on=1, load A=0x57 B=0x1A, start ADD -> curr_state 00->01->11->01; one cycle after start valid=1, out=0x71, carry=0, zero=0.
- Same operands, run SUB, AND, OR, XOR, NOT in turn -> out = 0x3D, 0x12, 0x5F, 0x4D, 0xA8 respectively; err=0 throughout.
- MUL 0x57*0x1A -> busy high for 8 cycles; valid at start+9; out=0xD6, out_hi=0x08, ovf=1. in_sel=load during BUSY leaves A/B unchanged.
- out_sel=7'b0000000, then 7'b1100000 -> valid pulse each, out=0, err=1. A following legal ADD clears err.
- Drop on=0 at MUL cycle 4 -> next state OFF, no valid, out holds prior value. on=1 -> READY.
- Assert rst mid-BUSY, asynchronously between edges -> state, out, flags, A, B all 0 immediately. Also: load 0xFF and 0x01, ADD -> out=0x00, carry=1, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU core.
//   state_t          - controller state encoding (exported on curr_state/next_state)
//   OP_*             - bit positions inside the one-hot out_sel vector
//   SEL_*            - bit positions inside the one-hot in_sel vector
//   is_onehot7()     - legality test for out_sel
package alu_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_READY = 2'b01,
    ST_BUSY  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int unsigned OP_ADD = 6;
  localparam int unsigned OP_SUB = 5;
  localparam int unsigned OP_MUL = 4;
  localparam int unsigned OP_AND = 3;
  localparam int unsigned OP_OR  = 2;
  localparam int unsigned OP_XOR = 1;
  localparam int unsigned OP_NOT = 0;

  localparam int unsigned SEL_PERSIST = 2;
  localparam int unsigned SEL_LOAD    = 1;
  localparam int unsigned SEL_RESET   = 0;

  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != '0) && ((v & (v - 7'd1)) == '0);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: shift-add multiplier, one multiplier bit per cycle.
//   clk, rst  - clock, asynchronous active-low reset
//   go        - snapshot a/b and start a multiply
//   abort     - cancel any multiply in flight (takes priority over go)
//   a, b      - WIDTH-bit unsigned operands
//   done      - one-cycle pulse; product is final while done is high
//   product   - full 2*WIDTH-bit product
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // The partial product for b[0] is folded into the go cycle, so done
  // rises after WIDTH-1 further steps and the product is ready to be
  // captured on the WIDTH-th edge after go.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (go) begin
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      cnt    <= CW'(WIDTH-1);
      done   <= 1'b0;
    end else if (cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      done   <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU with registered operands, 4-state controller,
// registered result/flags and a multi-cycle multiplier.
//   clk, rst          - clock, asynchronous active-low reset
//   on                - enable; low forces OFF and aborts a multiply
//   in_sel[2:0]       - operand select: persist / load / reset (reset wins)
//   num1, num2        - operand A/B sources
//   out_sel[6:0]      - one-hot op: ADD SUB MUL AND OR XOR NOT(A)
//   start             - execute request, honoured only in READY
//   out, out_hi       - result (out_hi is the MUL high half, else 0)
//   carry, ovf, zero  - status flags of the last completed op
//   err               - last op had an illegal out_sel
//   valid, busy       - high in DONE / BUSY respectively
//   curr_state        - registered state; next_state - combinational next
module alu_seq_core import alu_pkg::*; #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             err,
  output logic             valid,
  output logic             busy,
  output logic [1:0]       curr_state,
  output logic [1:0]       next_state
);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic               op_legal, is_mul, launch, mul_go, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v, res_z, res_e;

  assign op_legal = is_onehot7(out_sel);
  assign is_mul   = op_legal && out_sel[OP_MUL];
  assign launch   = on && (state == ST_READY) && start;
  assign mul_go   = launch && is_mul;

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = a_q - b_q;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .go      (mul_go),
    .abort   (!on),
    .a       (a_q),
    .b       (b_q),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle ops; MUL is produced by u_mul instead.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    res_e = 1'b0;
    if (!op_legal) begin
      res_e = 1'b1;
    end else if (out_sel[OP_ADD]) begin
      res   = sum[WIDTH-1:0];
      res_c = sum[WIDTH];
      res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    end else if (out_sel[OP_SUB]) begin
      res   = diff;
      res_c = (a_q < b_q);
      res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
    end else if (out_sel[OP_AND]) begin
      res = a_q & b_q;
    end else if (out_sel[OP_OR]) begin
      res = a_q | b_q;
    end else if (out_sel[OP_XOR]) begin
      res = a_q ^ b_q;
    end else if (out_sel[OP_NOT]) begin
      res = ~a_q;
    end
    res_z = op_legal && (res == '0);
  end

  always_comb begin
    state_nx = state;
    if (!on) begin
      state_nx = ST_OFF;
    end else begin
      unique case (state)
        ST_OFF:   state_nx = ST_READY;
        ST_READY: if (start) state_nx = is_mul ? ST_BUSY : ST_DONE;
        ST_BUSY:  if (mul_done) state_nx = ST_DONE;
        ST_DONE:  state_nx = ST_READY;
        default:  state_nx = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_OFF;
      a_q    <= '0;
      b_q    <= '0;
      out    <= '0;
      out_hi <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_nx;
      valid <= (state_nx == ST_DONE);
      busy  <= (state_nx == ST_BUSY);

      if (state != ST_BUSY) begin
        if (in_sel[SEL_RESET]) begin
          a_q <= '0;
          b_q <= '0;
        end else if (in_sel[SEL_LOAD]) begin
          a_q <= num1;
          b_q <= num2;
        end else if (in_sel[SEL_PERSIST]) begin
          a_q <= a_q;
          b_q <= b_q;
        end
      end

      if (launch && !is_mul) begin
        out    <= res;
        out_hi <= '0;
        carry  <= res_c;
        ovf    <= res_v;
        zero   <= res_z;
        err    <= res_e;
      end else if (on && (state == ST_BUSY) && mul_done) begin
        out    <= mul_prod[WIDTH-1:0];
        out_hi <= mul_prod[2*WIDTH-1:WIDTH];
        carry  <= 1'b0;
        ovf    <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
        zero   <= (mul_prod == '0);
        err    <= 1'b0;
      end
    end
  end

  assign curr_state = state;
  assign next_state = state_nx;

endmodule
